// File: rtl/unsigned_int_to_single.sv
// rtl/unsigned_int_to_single.sv - 32-bit unsigned integer to IEEE-754 single, RNE, 3-stage stb/ack pipeline
// Optional out_inexact port enabled by defining UINT_TO_SINGLE_INEXACT_EN.
module unsigned_int_to_single (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_a,
  input  logic        in_a_stb,
  output logic        in_a_ack,
  output logic [31:0] out_z,
  output logic        out_z_stb,
`ifdef UINT_TO_SINGLE_INEXACT_EN
  output logic        out_inexact,
`endif
  input  logic        out_z_ack
);

  // S1 capture registers
  logic        v1;
  logic [31:0] a1;
  logic        z1;
  logic [4:0]  lz1;

  // S2 normalise registers
  logic        v2;
  logic        z2;
  logic [7:0]  e2;
  logic [22:0] frac2;
  logic        g2;
  logic        s2;

  // S3 output registers
  logic        v3;
  logic [31:0] z3;
`ifdef UINT_TO_SINGLE_INEXACT_EN
  logic        inexact3;
`endif

  logic        ld1;
  logic        ld2;
  logic        ld3;

  logic [4:0]  lz_c;
  logic [30:0] m_c;
  logic [7:0]  e_c;
  logic        rnd_c;
  logic [23:0] sum_c;
  logic [7:0]  e_r_c;
  logic [31:0] z_c;

  // A stage may load when it is empty or its content moves on this cycle;
  // the chain runs back from out_z_ack so a full pipeline shifts without a bubble.
  always_comb begin
    ld3      = !v3 || out_z_ack;
    ld2      = !v2 || ld3;
    ld1      = !v1 || ld2;
    in_a_ack = rst_n && ld1;
  end

  always_comb begin
    lz_c = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (in_a[i]) lz_c = 5'(31 - i);
    end
  end

  always_comb begin
    m_c = 31'(a1 << lz1);
    e_c = 8'd158 - {3'd0, lz1};
  end

  // A carry out of the fraction leaves it at zero and bumps the exponent.
  always_comb begin
    rnd_c = g2 && (s2 || frac2[0]);
    sum_c = {1'b0, frac2} + {23'd0, rnd_c};
    e_r_c = e2 + {7'd0, sum_c[23]};
    z_c   = z2 ? 32'h0000_0000 : {1'b0, e_r_c, sum_c[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= 32'd0;
      z1  <= 1'b0;
      lz1 <= 5'd0;
    end else if (ld1) begin
      v1 <= in_a_stb;
      if (in_a_stb) begin
        a1  <= in_a;
        z1  <= (in_a == 32'd0);
        lz1 <= lz_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      z2    <= 1'b0;
      e2    <= 8'd0;
      frac2 <= 23'd0;
      g2    <= 1'b0;
      s2    <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        z2    <= z1;
        e2    <= e_c;
        frac2 <= m_c[30:8];
        g2    <= m_c[7];
        s2    <= |m_c[6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      z3 <= 32'd0;
`ifdef UINT_TO_SINGLE_INEXACT_EN
      inexact3 <= 1'b0;
`endif
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        z3 <= z_c;
`ifdef UINT_TO_SINGLE_INEXACT_EN
        inexact3 <= g2 || s2;
`endif
      end
    end
  end

  assign out_z     = z3;
  assign out_z_stb = v3;
`ifdef UINT_TO_SINGLE_INEXACT_EN
  assign out_inexact = inexact3;
`endif

endmodule

// File: tb/tb_unsigned_int_to_single.sv
// tb/tb_unsigned_int_to_single.sv - randomized self-checking bench for unsigned_int_to_single
module tb_unsigned_int_to_single;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic        in_a_stb = 1'b0;
  logic        in_a_ack;
  logic [31:0] out_z;
  logic        out_z_stb;
  logic        out_z_ack = 1'b1;
`ifdef UINT_TO_SINGLE_INEXACT_EN
  logic        out_inexact;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unsigned_int_to_single dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_a_stb  (in_a_stb),
    .in_a_ack  (in_a_ack),
    .out_z     (out_z),
    .out_z_stb (out_z_stb),
`ifdef UINT_TO_SINGLE_INEXACT_EN
    .out_inexact (out_inexact),
`endif
    .out_z_ack (out_z_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: nearest representable value with 24 significant bits, ties to even.
  function automatic longint unsigned ref_round(input logic [31:0] a, output bit inexact);
    longint unsigned v, p, ulp, q, r;
    v = {32'd0, a};
    inexact = 1'b0;
    if (v == 0) return 0;
    p = 0;
    while ((64'd1 << (p + 1)) <= v) p++;
    ulp = (p > 23) ? (64'd1 << (p - 23)) : 64'd1;
    q = v / ulp;
    r = v % ulp;
    inexact = (r != 0);
    if ((2 * r > ulp) || ((2 * r == ulp) && (q % 2 == 1))) q++;
    return q * ulp;
  endfunction

  function automatic logic [31:0] encode(input longint unsigned v);
    longint unsigned p, mant;
    if (v == 0) return 32'd0;
    p = 0;
    while ((64'd1 << (p + 1)) <= v) p++;
    mant = (p > 23) ? (v >> (p - 23)) : (v << (23 - p));
    return {1'b0, 8'(127 + p), mant[22:0]};
  endfunction

  // Float back to integer, as the downstream single_to_unsigned_int stage would.
  function automatic longint unsigned decode(input logic [31:0] z);
    int e;
    longint unsigned m;
    if (z == 32'd0) return 0;
    e = int'(z[30:23]);
    m = {40'd0, 1'b1, z[22:0]};
    if (e >= 150) return m << (e - 150);
    return m >> (150 - e);
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 4))
      0: return x;
      1: return 32'($urandom_range(0, 1024));
      2: return x >> $urandom_range(0, 31);
      3: begin
        x = x >> $urandom_range(0, 7);
        x[31 - 7] = 1'b1;
        x[7:0] = 8'($urandom_range(32'h7F, 32'h81));
        return x;
      end
      default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
    endcase
  endfunction

  logic [31:0]     exp_q[$];
  longint unsigned val_q[$];
`ifdef UINT_TO_SINGLE_INEXACT_EN
  bit              inx_q[$];
`endif

  task automatic push_exp(input logic [31:0] a);
    bit ix;
    longint unsigned r;
    r = ref_round(a, ix);
    exp_q.push_back(encode(r));
    val_q.push_back(r);
`ifdef UINT_TO_SINGLE_INEXACT_EN
    inx_q.push_back(ix);
`endif
  endtask

  bit              mon_en = 1'b0;
  bit              hold_prev = 1'b0;
  logic [31:0]     z_prev = 32'd0;
  logic [31:0]     ez;
  longint unsigned ev;

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        check("stall_stb", {63'd0, out_z_stb}, 64'd1);
        check("stall_z", {32'd0, out_z}, {32'd0, z_prev});
      end
      if (out_z_stb && out_z_ack) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          ez = exp_q.pop_front();
          ev = val_q.pop_front();
          check("rand_z", {32'd0, out_z}, {32'd0, ez});
          check("roundtrip", decode(out_z), ev);
`ifdef UINT_TO_SINGLE_INEXACT_EN
          check("rand_inexact", {63'd0, out_inexact}, {63'd0, inx_q.pop_front()});
`endif
        end
      end
      hold_prev = out_z_stb && !out_z_ack;
      z_prev    = out_z;
    end else begin
      hold_prev = 1'b0;
    end
  end

  logic [31:0] d_in[10] = '{32'd0, 32'd1, 32'd2, 32'd255, 32'd16777216,
                            32'd16777217, 32'd16777219, 32'd16777218,
                            32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] d_z[10]  = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h437F_0000,
                            32'h4B80_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0001,
                            32'h4F80_0000, 32'h4F00_0000};
  logic        d_ix[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] bp_in[4] = '{32'd10, 32'd20, 32'd30, 32'd40};
  logic [31:0] bp_z[4]  = '{32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000, 32'h4220_0000};

  initial begin
    int idx;
    int k;
    int n;
    int cnt;
    int sent;
    bit xfer;

    // reset state
    #12;
    check("rst_stb", {63'd0, out_z_stb}, 64'd0);
    check("rst_z", {32'd0, out_z}, 64'd0);
    check("rst_ack", {63'd0, in_a_ack}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ack", {63'd0, in_a_ack}, 64'd1);

    // directed values, back to back, fixed latency
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      out_z_ack = 1'b1;
      in_a_stb  = (c < 10);
      if (c < 10) in_a = d_in[c];
      @(negedge clk);
      if (c < 10) check($sformatf("dir_ack%0d", c), {63'd0, in_a_ack}, 64'd1);
      check($sformatf("dir_stb%0d", c), {63'd0, out_z_stb}, {63'd0, (c >= 3 && c < 13)});
      if (c >= 3 && c < 13) begin
        check($sformatf("dir_z%0d", c - 3), {32'd0, out_z}, {32'd0, d_z[c - 3]});
`ifdef UINT_TO_SINGLE_INEXACT_EN
        check($sformatf("dir_inexact%0d", c - 3), {63'd0, out_inexact}, {63'd0, d_ix[c - 3]});
`endif
      end
    end

    // backpressure: three accepted, fourth held, output stable
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_z_ack = 1'b0;
      in_a_stb  = 1'b1;
      in_a      = bp_in[idx];
      @(negedge clk);
      check($sformatf("bp_ack%0d", c), {63'd0, in_a_ack}, {63'd0, (c < 3)});
      if (in_a_ack) idx++;
      if (c >= 3) begin
        check("bp_hold_stb", {63'd0, out_z_stb}, 64'd1);
        check("bp_hold_z", {32'd0, out_z}, {32'd0, bp_z[0]});
      end
    end
    check("bp_accepted", 64'(idx), 64'd3);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      @(posedge clk); #1;
      out_z_ack = 1'b1;
      in_a_stb  = (idx < 4);
      if (idx < 4) in_a = bp_in[idx];
      @(negedge clk);
      if (in_a_stb && in_a_ack) idx++;
      if (out_z_stb && out_z_ack) begin
        check($sformatf("bp_z%0d", k), {32'd0, out_z}, {32'd0, bp_z[k]});
        k++;
      end
    end
    check("bp_in_count", 64'(idx), 64'd4);
    check("bp_out_count", 64'(k), 64'd4);
    @(posedge clk); #1;
    in_a_stb = 1'b0;

    // reset with a full pipeline
    n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(posedge clk); #1;
      out_z_ack = 1'b0;
      in_a_stb  = 1'b1;
      in_a      = 32'(n + 1);
      @(negedge clk);
      if (in_a_ack) n++;
    end
    check("rst_fill", 64'(n), 64'd3);
    @(posedge clk); #1;
    in_a_stb = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stb", {63'd0, out_z_stb}, 64'd0);
    check("mid_rst_z", {32'd0, out_z}, 64'd0);
    check("mid_rst_ack", {63'd0, in_a_ack}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ack", {63'd0, in_a_ack}, 64'd1);
    check("post_rst_stb", {63'd0, out_z_stb}, 64'd0);
    @(posedge clk); #1;
    out_z_ack = 1'b1;
    in_a_stb  = 1'b1;
    in_a      = 32'd7;
    @(negedge clk);
    check("post_rst_accept", {63'd0, in_a_ack}, 64'd1);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_a_stb = 1'b0;
      @(negedge clk);
      if (out_z_stb && out_z_ack) begin
        cnt++;
        check("post_rst_z", {32'd0, out_z}, 64'h40E0_0000);
      end
    end
    check("post_rst_count", 64'(cnt), 64'd1);

    // random regression against the reference model
    mon_en = 1'b1;
    sent   = 0;
    xfer   = 1'b0;
    for (int c = 0; c < 40000 && sent < 5000; c++) begin
      @(posedge clk); #1;
      out_z_ack = ($urandom_range(0, 3) != 0);
      if (!in_a_stb || xfer) begin
        in_a_stb = ($urandom_range(0, 4) != 0);
        in_a     = rand_val();
      end
      xfer = 1'b0;
      @(negedge clk);
      if (in_a_stb && in_a_ack) begin
        push_exp(in_a);
        sent++;
        xfer = 1'b1;
      end
    end
    check("rand_sent", 64'(sent), 64'd5000);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      in_a_stb  = 1'b0;
      out_z_ack = 1'b1;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unsigned_int_to_single.md
Name: unsigned_int_to_single

Overview:
- Converts a 32-bit unsigned integer to an IEEE-754 single-precision value.
- Rounding is round-to-nearest-even.
- Inverse neighbour of single_to_unsigned_int: it generates float operands for that stage and for the rest of the float library, e.g. for int-to-float-to-int round-trip benches.
- Three-stage pipeline with stb/ack handshakes on input and output, and full backpressure.

Parameters:
- None. Width is fixed at 32 in and 32 out to match the single-precision library.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_a  in  32  unsigned integer operand
- in_a_stb  in  1  in_a valid
- in_a_ack  out  1  block accepts in_a this cycle; transfer occurs when in_a_stb && in_a_ack at posedge
- out_z  out  32  single-precision result
- out_z_stb  out  1  out_z valid
- out_z_ack  in  1  consumer takes out_z; transfer occurs when out_z_stb && out_z_ack at posedge

Behaviour:
- Reset (rst_n low, asynchronous): clear all stage valid bits, out_z=0, out_z_stb=0, all internal data registers=0.
  - in_a_ack is low while rst_n is low and high on the first cycle after release.
  - In-flight operands are discarded; nothing is emitted after reset for pre-reset inputs.
- Stage S1 (capture):
  - Register a and zero flag (a==0).
  - Compute lz = leading-zero count (0..31; don't-care when zero).
- Stage S2 (normalise):
  - m = a << lz (bit 31 set unless zero).
  - Exponent e = 158 - lz, 8 bits.
  - frac = m[30:8], guard = m[7], sticky = |m[6:0].
- Stage S3 (round/pack):
  - Round up if guard && (sticky || frac[0]).
  - frac+1 overflow (frac all ones) -> frac=0, e=e+1.
  - out_z = {1'b0, e, frac}.
  - Zero input -> out_z = 32'h00000000.
  - Sign always 0. No NaN/Inf/denormal is ever produced; max input gives 0x4F800000.
- Latency: 3 cycles from input transfer to out_z_stb high with no stall; throughput 1 per cycle.
- Handshake/stall:
  - Each stage register holds a valid bit.
  - Stage k loads when (stage k empty) or (stage k advancing); otherwise it holds.
  - S3 advances on out_z_ack.
  - in_a_ack = !v1 || advance1. This is a combinational chain from out_z_ack, which is permitted.
  - Capacity 3 words: with out_z_ack held low, exactly 3 operands are accepted, then in_a_ack=0.
  - out_z and out_z_stb are stable while out_z_stb && !out_z_ack.
- Simultaneous accept and emit on a full pipeline: all stages shift, no bubble, no loss.
- Data order is preserved strictly FIFO.

Optional Feature:
- Macro UINT_TO_SINGLE_INEXACT_EN.
- When defined:
  - Adds output port out_inexact (out, 1), = guard|sticky of the result, aligned with out_z.
  - Held with out_z during stall; reset value 0.
- When undefined:
  - Port absent; guard/sticky are used only for rounding.
  - No other behaviour change.

Test Plan:
- Basic values, no stall: in_a = 0, 1, 2, 255, 16777216 -> out_z = 0x00000000, 0x3F800000, 0x40000000, 0x437F0000, 0x4B800000. Each appears exactly 3 cycles after acceptance, back-to-back.
- Rounding ties: 16777217 -> 0x4B800000 (tie, even, down); 16777219 -> 0x4B800002 (tie, up); 16777218 -> 0x4B800001 exact. Inexact (if enabled) = 1, 1, 0.
- Overflow carry: 0xFFFFFFFF -> 0x4F800000; 0x80000000 -> 0x4F000000. Inexact = 1, 0.
- Backpressure: out_z_ack=0, stream 10, 20, 30, 40 -> in_a_ack falls after 3 accepts and 40 is held. Then release ack -> outputs 0x41200000, 0x41A00000, 0x41F00000, 0x42200000 in order, with out_z stable during stall.
- Reset mid-stream: assert rst_n low with 3 words in flight -> out_z_stb=0 and out_z=0 immediately. After release, a new input 7 -> only 0x40E00000 emitted.
- Random regression: 5000 random in_a, random ack gaps -> compare against a float cast model. Each output fed through single_to_unsigned_int returns the rounded integer.
